// File: rtl/mtx_mvmul_engine_pkg.sv
// mtx_mvmul_engine_pkg: shared MVMUL types, sizes and ternary arithmetic helpers
package mtx_mvmul_engine_pkg;
  localparam int R = 16;
  localparam int C = 16;
  localparam int V = 16;
  localparam int Q = 31;
  localparam int SW = 37;
  typedef enum logic [1:0] {ZERO = 2'b00, PLUS = 2'b01, MINUS = 2'b10} val3_t;
  typedef logic signed [Q:0] q31_t;
  typedef logic signed [Q+1:0] p33_t;
  typedef logic signed [SW-1:0] acc_t;
  typedef logic [C-1:0][1:0] row3_t;
  typedef q31_t [V-1:0] qvec_t;
  typedef struct packed { row3_t [R-1:0] data3; } mtx_t;
  typedef struct packed { qvec_t vec; } vec_t;
  typedef union packed { mtx_t mtx; vec_t vec; } mv_t;
  typedef struct packed { logic of; logic uf; logic zero; logic inv; } status_t;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} mvmul_state_t;
  localparam acc_t S_MAX = acc_t'(32'sh7FFF_FFFF);
  localparam acc_t S_MIN = -S_MAX;
  localparam acc_t S_NEG = S_MIN - acc_t'(1);
  function automatic q31_t mul3(input logic [1:0] w, input q31_t x);
    return w == PLUS ? x : w == MINUS ? -x : '0;
  endfunction
  // Sign-extend before negating so -0x80000000 stays exact.
  function automatic p33_t mul3_w(input logic [1:0] w, input q31_t x);
    p33_t e;
    e = {x[Q], x};
    return w == PLUS ? e : w == MINUS ? -e : '0;
  endfunction
  function automatic q31_t sat(input acc_t s);
    return s > S_MAX ? 32'h7FFF_FFFF : s < S_MIN ? 32'h8000_0000 : s[31:0];
  endfunction
endpackage

// File: rtl/mtx_mvmul_engine_if.sv
// mtx_mvmul_engine_if: operand and result valid/ready bundle for the MVMUL engine
interface mtx_mvmul_engine_if;
  import mtx_mvmul_engine_pkg::*;
  logic in_valid;
  logic in_ready;
  mv_t in_mtx;
  mv_t in_vec;
  logic out_valid;
  logic out_ready;
  mv_t out_res;
  status_t out_status;
  modport master (output in_valid, in_mtx, in_vec, out_ready, input in_ready, out_valid, out_res, out_status);
  modport slave (input in_valid, in_mtx, in_vec, out_ready, output in_ready, out_valid, out_res, out_status);
endinterface

// File: rtl/mtx_mvmul_engine_row.sv
// mtx_mvmul_engine_row: one ternary row dot product with exact sum, saturation and row flags
module mtx_mvmul_row
  import mtx_mvmul_engine_pkg::*;
(
  input  row3_t row,
  input  qvec_t vec,
  output q31_t  res,
  output logic  of,
  output logic  uf,
  output logic  inv
);
  acc_t [C-1:0] t;
  always_comb begin
    for (int c = 0; c < C; c++) t[c] = acc_t'(mul3_w(row[c], vec[c]));
    for (int w = C / 2; w > 0; w = w / 2)
      for (int i = 0; i < w; i++) t[i] = t[2*i] + t[2*i+1];
  end
  always_comb begin
    inv = 1'b0;
    for (int c = 0; c < C; c++) inv = inv | (row[c] == 2'b11);
  end
  assign res = sat(t[0]);
  assign of  = t[0] > S_MAX;
  assign uf  = t[0] < S_NEG;
endmodule

// File: rtl/mtx_mvmul_engine.sv
// mtx_mvmul_engine: row-sequential ternary matrix x Q31 vector multiply; flags gated by MTX_MVMUL_STATUS_EN
module mtx_mvmul_engine
  import mtx_mvmul_engine_pkg::*;
(
  input logic clk,
  input logic rst_n,
  mtx_mvmul_engine_if.slave bus
);
  localparam int RW = $clog2(R);
  mvmul_state_t state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  mtx_t mtx_q, mtx_d;
  qvec_t vec_q, vec_d;
  qvec_t res_q, res_d;
  q31_t row_res;
  logic row_of, row_uf, row_inv;
  logic accept, busy, last;
  assign accept = state_q == IDLE && bus.in_valid;
  assign busy   = state_q == BUSY;
  assign last   = row_q == RW'(R - 1);
  mtx_mvmul_row u_row (
    .row (mtx_q.data3[row_q]),
    .vec (vec_q),
    .res (row_res),
    .of  (row_of),
    .uf  (row_uf),
    .inv (row_inv)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      row_q   <= '0;
      mtx_q   <= '0;
      vec_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      mtx_q   <= mtx_d;
      vec_q   <= vec_d;
      res_q   <= res_d;
    end
  end
  always_comb
    state_d = state_q == IDLE ? (bus.in_valid ? BUSY : IDLE) :
              state_q == BUSY ? (last ? DONE : BUSY) :
              (bus.out_ready ? IDLE : DONE);
  always_comb begin
    row_d = row_q;
    mtx_d = mtx_q;
    vec_d = vec_q;
    res_d = res_q;
    if (accept) begin
      mtx_d = bus.in_mtx.mtx;
      vec_d = bus.in_vec.vec.vec;
      res_d = '0;
      row_d = '0;
    end else if (busy) begin
      res_d[row_q] = row_res;
      row_d = row_q + 1'b1;
    end
  end
`ifdef MTX_MVMUL_STATUS_EN
  status_t status_q, status_d;
  logic nz_q, nz_d;
  // nz tracks any nonzero result so far; zero resolves on the final row write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      status_q <= '0;
      nz_q     <= 1'b0;
    end else begin
      status_q <= status_d;
      nz_q     <= nz_d;
    end
  end
  always_comb begin
    status_d = status_q;
    nz_d = nz_q;
    if (accept) begin
      status_d = '0;
      nz_d = 1'b0;
    end else if (busy) begin
      nz_d = nz_q | (row_res != '0);
      status_d.of = status_q.of | row_of;
      status_d.uf = status_q.uf | row_uf;
      status_d.inv = status_q.inv | row_inv;
      status_d.zero = last & ~nz_d;
    end
  end
`else
  logic unused_flags;
  assign unused_flags = row_of ^ row_uf ^ row_inv;
`endif
  always_comb begin
    bus.in_ready = state_q == IDLE;
    bus.out_valid = state_q == DONE;
    bus.out_res = mv_t'(res_q);
`ifdef MTX_MVMUL_STATUS_EN
    bus.out_status = status_q;
`else
    bus.out_status = '0;
`endif
  end
endmodule

// File: tb/tb_mtx_mvmul_engine.sv
// tb_mtx_mvmul_engine: directed and randomized MVMUL operations checked against an integer reference model
module tb_mtx_mvmul_engine;
  import mtx_mvmul_engine_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  mtx_mvmul_engine_if bus();
  mtx_mvmul_engine dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int nchk = 0;
  int nerr = 0;
  mv_t exp_res;
  status_t exp_st;
  localparam longint LIM = 64'sd2147483647;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic void model(input mv_t m, input mv_t v);
    longint s, x;
    logic allz;
    status_t st;
    allz = 1'b1;
    st = '0;
    for (int r = 0; r < R; r++) begin
      s = 0;
      for (int c = 0; c < C; c++) begin
        x = longint'($signed(v.vec.vec[c]));
        if (m.mtx.data3[r][c] == 2'b01) s = s + x;
        else if (m.mtx.data3[r][c] == 2'b10) s = s - x;
        else if (m.mtx.data3[r][c] == 2'b11) st.inv = 1'b1;
      end
      exp_res.vec.vec[r] = s > LIM ? 32'h7FFF_FFFF : s < -LIM ? 32'h8000_0000 : s[31:0];
      if (s > LIM) st.of = 1'b1;
      if (s < -LIM - 1) st.uf = 1'b1;
      if (exp_res.vec.vec[r] != 0) allz = 1'b0;
    end
    st.zero = allz;
`ifndef MTX_MVMUL_STATUS_EN
    st = '0;
`endif
    exp_st = st;
  endfunction
  function automatic mv_t rnd_mtx(input bit allow3);
    mv_t m;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        m.mtx.data3[r][c] = allow3 ? 2'($urandom_range(0, 3)) : 2'($urandom_range(0, 2));
    return m;
  endfunction
  function automatic mv_t rnd_vec();
    mv_t v;
    for (int c = 0; c < V; c++) begin
      case ($urandom_range(0, 3))
        0: v.vec.vec[c] = $urandom();
        1: v.vec.vec[c] = 32'h7FFF_FFFF;
        2: v.vec.vec[c] = 32'h8000_0000;
        default: v.vec.vec[c] = 32'($urandom_range(0, 15)) - 32'd8;
      endcase
    end
    return v;
  endfunction
  task automatic accept_op(input mv_t m, input mv_t v);
    int n;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      tick;
      n++;
    end
    check("in_ready_before_accept", bus.in_ready, 1);
    bus.in_mtx = m;
    bus.in_vec = v;
    bus.in_valid = 1'b1;
    tick;
    bus.in_valid = 1'b0;
  endtask
  task automatic run_op(input string tag, input mv_t m, input mv_t v, input int hold);
    int n;
    model(m, v);
    accept_op(m, v);
    n = 0;
    while (!bus.out_valid && n < 40) begin
      tick;
      n++;
    end
    check({tag, "_latency"}, n, 16);
    check({tag, "_res"}, bus.out_res, exp_res);
    check({tag, "_status"}, bus.out_status, exp_st);
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_mtx = rnd_mtx(1'b1);
      bus.in_vec = rnd_vec();
      tick;
      check({tag, "_hold_res"}, bus.out_res, exp_res);
      check({tag, "_hold_status"}, bus.out_status, exp_st);
      check({tag, "_hold_in_ready"}, bus.in_ready, 0);
      check({tag, "_hold_out_valid"}, bus.out_valid, 1);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick;
    bus.out_ready = 1'b0;
    check({tag, "_in_ready_after"}, bus.in_ready, 1);
    check({tag, "_out_valid_after"}, bus.out_valid, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    mv_t m, v, idm, idv;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_mtx = '0;
    bus.in_vec = '0;
    tick;
    tick;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_res", bus.out_res, 0);
    check("rst_out_status", bus.out_status, 0);
    rst_n = 1'b1;
    tick;
    check("rel_in_ready", bus.in_ready, 1);
    idm = '0;
    idv = '0;
    for (int r = 0; r < R; r++) idm.mtx.data3[r][r] = 2'b01;
    for (int c = 0; c < V; c++) idv.vec.vec[c] = 32'(c + 1);
    run_op("identity", idm, idv, 0);
    check("identity_row15", exp_res.vec.vec[15], 16);
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) m.mtx.data3[r][c] = r == 0 ? 2'b10 : 2'b01;
    for (int c = 0; c < V; c++) v.vec.vec[c] = 32'h7FFF_FFFF;
    run_op("negsat", m, v, 0);
    m = '0;
    v = '0;
    m.mtx.data3[0][0] = 2'b10;
    v.vec.vec[0] = 32'h8000_0000;
    run_op("negedge", m, v, 0);
    m = '1;
    v = rnd_vec();
    v.vec.vec[0] = 32'd5;
    run_op("invalid", m, v, 0);
    run_op("backpressure", rnd_mtx(1'b0), rnd_vec(), 5);
    accept_op(idm, idv);
    for (int i = 0; i < 7; i++) tick;
    rst_n = 1'b0;
    tick;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_out_res", bus.out_res, 0);
    check("midrst_out_status", bus.out_status, 0);
    rst_n = 1'b1;
    tick;
    check("midrst_in_ready", bus.in_ready, 1);
    run_op("identity_after_rst", idm, idv, 0);
    for (int k = 0; k < 20; k++)
      run_op($sformatf("rand%0d", k), rnd_mtx(k % 4 == 0), rnd_vec(), k % 3);
    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end
endmodule

// File: doc/mtx_mvmul_engine.md
# mtx_mvmul_engine

Sequential ternary matrix–vector multiply engine that executes the MVMUL operation (V0 = M0 × V0) for the VLIW datapath. It accepts a 16×16 ternary matrix and a 16-element Q31 vector as `mv_t` words through a valid/ready handshake. It computes one output row per cycle with exact accumulation and saturation, then presents the result vector and a `status_t` flag word downstream through a second valid/ready handshake.

## Interface
Parameters (from the shared package, not overridable per instance):
- R, 16, output rows / row counter range
- C, 16, columns per row; must equal V
- V, 16, vector length

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  one clock; reset is synchronous and active-low
- in_valid  in  1  operand pair valid
- in_ready  out  1  engine can accept operands (high only in IDLE)
- in_mtx  in  512  `mv_t`, `mtx.data3[r][c]` = weight of row r, column c
- in_vec  in  512  `mv_t`, `vec.vec[c]` = Q31 input element c
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_res  out  512  `mv_t`, `vec.vec[r]` = result row r
- out_status  out  4  `status_t` {of, uf, zero, inv}

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: in_ready=1. When in_valid && in_ready at an edge, latch in_mtx/in_vec, clear out_res and sticky flags, row←0, go to BUSY.
- BUSY: each edge writes out_res.vec[row] = sat(S_row) and ORs in that row's flags, then row++. The edge that writes row R-1 goes to DONE. in_valid is ignored.
- DONE: out_valid=1. out_res and out_status are held stable. When out_valid && out_ready at an edge, go to IDLE. in_ready rises the following cycle; there is no same-cycle accept.
- Arithmetic:
  - Each product is 33-bit signed: PLUS gives x, MINUS gives -x with sign extension before negation (-0x80000000 = +0x80000000 exact), ZERO or code 2'b11 gives 0.
  - S_row is the exact sum of C products in at least 37-bit signed.
  - The result uses the package `sat`: S>0x7FFFFFFF gives 0x7FFFFFFF; S<-0x7FFFFFFF gives 0x80000000; otherwise S[31:0].
- Flags are sticky across the run and cleared at accept:
  - of: any S_row > 0x7FFFFFFF
  - uf: any S_row < -0x80000000
  - zero: all R results equal 0, evaluated at the final row write
  - inv: any latched matrix element equal to 2'b11
- Reset (rst_n=0 at an edge, in any state, including mid-BUSY):
  - state←IDLE, row←0, out_valid←0, out_res←0, out_status←0.
  - The in-flight operation is discarded.
  - in_ready=1 in the first cycle after reset is released.

## Timing
- Accept at edge T. Row r is written at edge T+1+r. out_valid is high from edge T+R (=T+16) onward.
- Latency from accept to out_valid is 16 cycles.
- Minimum issue interval is 18 cycles: 16 BUSY cycles, 1 DONE cycle with out_ready=1, and 1 IDLE cycle.
- out_res and out_status are registered outputs with no combinational path from inputs. in_ready and out_valid decode directly from the state register.

## Configuration
- Macro: MTX_MVMUL_STATUS_EN.
- Defined: the flag logic is compiled in and out_status behaves as specified above.
- Undefined: the flag logic is removed and out_status is tied to 4'b0. The port stays present, and results and timing are identical.

## Structure
- Existing shared package content to reuse: R, C, V, Q, `val3_t`, `q31_t`, `mv_t`, `status_t`, `sat`.
- Additions to the shared package:
  - `mvmul_state_t` enum {IDLE, BUSY, DONE}
  - `mul3_w` function returning the 33-bit product; the existing `mul3` wraps on -0x80000000 and is not used here
- Sub-module `mtx_mvmul_row`:
  - Combinational: one matrix row plus the vector → 32-bit saturated result and per-row {of, uf, inv}.
  - Internally 16 `mul3_w` calls and an adder tree.
  - Instantiated once and muxed by the row counter.

## Test plan
- Identity: diagonal PLUS, all other elements ZERO, vec[c]=c+1. Required: out_res.vec[r]=r+1, status=0000, out_valid exactly 16 cycles after the accept edge.
- Negative saturation: all PLUS and vec all 0x7FFFFFFF, except row 0 all MINUS. Required: row 0 = 0x80000000, other rows = 0x7FFFFFFF, of=1, uf=1.
- Negation edge: row 0 has a single MINUS at column 0, vec[0]=0x80000000, all other elements ZERO. Required: row 0 = 0x7FFFFFFF, of=1, uf=0, rows 1–15 = 0.
- Invalid code: every element 2'b11, arbitrary nonzero vec. Required: all results 0, zero=1, inv=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid rises. Required: out_res/out_status stable, in_ready=0, in_valid pulses ignored. When out_ready=1, in_ready=1 on the next cycle.
- Reset mid-op: drive rst_n=0 at the edge that would write row 7. Required: next cycle out_valid=0, out_res=0, out_status=0, in_ready=1 after release, and a fresh identity operation completes correctly.
